// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the CDB arbiter and its round-robin picker.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_IDX_LN = 5;
  localparam int unsigned WORD_LN    = 32;

  // Requester slot assignment on the shared CDB.
  typedef enum logic [2:0] {
    CDB_REQ_ALU = 3'd0,
    CDB_REQ_LD  = 3'd1
  } cdb_req_e;

  // Round-robin successor; wraps with an explicit compare so non power-of-two
  // requester counts rotate correctly.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester / consumer bundle of the CDB arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ROB_BIT = ROB_IDX_LN,
  parameter int unsigned WORD_W  = WORD_LN
);
  logic                        rdy;
  logic                        rb_flush;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ROB_BIT-1:0]  req_src;
  logic [NUM_REQ*WORD_W-1:0]   req_val;
  logic [NUM_REQ-1:0]          req_tk;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        cdb_valid;
  logic [ROB_BIT-1:0]          cdb_src;
  logic [WORD_W-1:0]           cdb_val;
  logic                        cdb_tk;

  modport master (
    output rdy, rb_flush, req_valid, req_src, req_val, req_tk,
    input  req_ready, cdb_valid, cdb_src, cdb_val, cdb_tk
  );

  modport slave (
    input  rdy, rb_flush, req_valid, req_src, req_val, req_tk,
    output req_ready, cdb_valid, cdb_src, cdb_val, cdb_tk
  );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin selector: first pending index at or after rr_ptr.
module rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N-1:0]     pend,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  // Scan N slots starting at rr_ptr, keep the first pending hit.
  always_comb begin
    logic [PTR_W-1:0] pos;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    pos = rr_ptr;
    for (int unsigned k = 0; k < N; k++) begin
      if (!vld && pend[pos]) begin
        vld      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
      pos = PTR_W'(rr_next(32'(pos), N));
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB broadcast among result units.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ROB_BIT = ROB_IDX_LN,
  parameter int unsigned WORD_W  = WORD_LN
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [ROB_BIT-1:0] hsrc_q [NUM_REQ];
  logic [ROB_BIT-1:0] hsrc_d [NUM_REQ];
  logic [WORD_W-1:0]  hval_q [NUM_REQ];
  logic [WORD_W-1:0]  hval_d [NUM_REQ];
  logic [NUM_REQ-1:0] htk_q, htk_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [ROB_BIT-1:0] cdb_src_q, cdb_src_d;
  logic [WORD_W-1:0]  cdb_val_q, cdb_val_d;
  logic               cdb_tk_q, cdb_tk_d;

  logic [NUM_REQ-1:0] pick_gnt, gnt, ready, accept;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld, gnt_vld, gnt_en;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .pend   (pend_q),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .vld    (pick_vld)
  );

  // Grant and hand-over readiness; a granted slot may refill in the same cycle.
  always_comb begin
    gnt_en  = bus.rdy && !bus.rb_flush && !rst;
    gnt     = pick_gnt & {NUM_REQ{gnt_en}};
    gnt_vld = pick_vld && gnt_en;
    ready   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ready[i] = gnt_en && (!pend_q[i] || gnt[i]);
    end
    accept = bus.req_valid & ready;
  end

  // Next state: flush outranks stall; otherwise broadcast winner and load accepts.
  always_comb begin
    pend_d      = pend_q;
    htk_d       = htk_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_src_d   = cdb_src_q;
    cdb_val_d   = cdb_val_q;
    cdb_tk_d    = cdb_tk_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hsrc_d[i] = hsrc_q[i];
      hval_d[i] = hval_q[i];
    end

    if (bus.rb_flush) begin
      pend_d      = '0;
      cdb_valid_d = 1'b0;
      rr_ptr_d    = '0;
    end else if (bus.rdy) begin
      cdb_valid_d = gnt_vld;
      if (gnt_vld) begin
        cdb_src_d = hsrc_q[pick_idx];
        cdb_val_d = hval_q[pick_idx];
        cdb_tk_d  = htk_q[pick_idx];
        rr_ptr_d  = PTR_W'(rr_next(32'(pick_idx), NUM_REQ));
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          pend_d[i] = 1'b0;
        end
        if (accept[i]) begin
          pend_d[i] = 1'b1;
          hsrc_d[i] = bus.req_src[i*ROB_BIT +: ROB_BIT];
          hval_d[i] = bus.req_val[i*WORD_W +: WORD_W];
          htk_d[i]  = bus.req_tk[i];
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      htk_q       <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= '0;
      cdb_val_q   <= '0;
      cdb_tk_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        hsrc_q[i] <= '0;
        hval_q[i] <= '0;
      end
    end else begin
      pend_q      <= pend_d;
      htk_q       <= htk_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_val_q   <= cdb_val_d;
      cdb_tk_q    <= cdb_tk_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        hsrc_q[i] <= hsrc_d[i];
        hval_q[i] <= hval_d[i];
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.cdb_val   = cdb_val_q;
  assign bus.cdb_tk    = cdb_tk_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: behavioural model checked every cycle plus directed literals.
module tb_cdb_arbiter;
  localparam int N  = 2;
  localparam int RB = 5;
  localparam int WW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .ROB_BIT(RB), .WORD_W(WW)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .ROB_BIT(RB), .WORD_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one holding slot per requester, a priority pointer, the last beat.
  bit            pend_m [N] = '{default: 1'b0};
  logic [RB-1:0] src_m  [N] = '{default: '0};
  logic [WW-1:0] val_m  [N] = '{default: '0};
  bit            tk_m   [N] = '{default: 1'b0};
  int            rr_m  = 0;
  bit            cv_m  = 1'b0;
  logic [RB-1:0] cs_m  = '0;
  logic [WW-1:0] cval_m = '0;
  bit            ct_m  = 1'b0;

  function automatic int winner();
    if (!bus.rdy || bus.rb_flush || rst) return -1;
    for (int k = 0; k < N; k++) begin
      if (pend_m[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    w = winner();
    for (int i = 0; i < N; i++)
      r[i] = bus.rdy && !bus.rb_flush && !rst && (!pend_m[i] || w == i);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    int w;
    logic [N-1:0] r;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        pend_m[i] = 0; src_m[i] = '0; val_m[i] = '0; tk_m[i] = 0;
      end
      rr_m = 0; cv_m = 0; cs_m = '0; cval_m = '0; ct_m = 0;
    end else begin
      w = winner();
      r = exp_ready();
      if (bus.rb_flush) begin
        for (int i = 0; i < N; i++) pend_m[i] = 0;
        cv_m = 0;
        rr_m = 0;
      end else if (bus.rdy) begin
        if (w >= 0) begin
          cv_m = 1; cs_m = src_m[w]; cval_m = val_m[w]; ct_m = tk_m[w];
          pend_m[w] = 0;
          rr_m = (w + 1) % N;
        end else begin
          cv_m = 0;
        end
        for (int i = 0; i < N; i++) begin
          if (bus.req_valid[i] && r[i]) begin
            pend_m[i] = 1;
            src_m[i]  = bus.req_src[i*RB +: RB];
            val_m[i]  = bus.req_val[i*WW +: WW];
            tk_m[i]   = bus.req_tk[i];
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ready", 64'(bus.req_ready), 64'(exp_ready()));
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(cv_m));
    chk("cdb_src", 64'(bus.cdb_src), 64'(cs_m));
    chk("cdb_val", 64'(bus.cdb_val), 64'(cval_m));
    chk("cdb_tk", 64'(bus.cdb_tk), 64'(ct_m));
  end

  task automatic drive(input logic [N-1:0] v, input int s0, input int v0, input int s1,
                       input int v1, input logic [N-1:0] tk, input logic r, input logic fl);
    bus.req_valid = v;
    bus.req_src   = {RB'(s1), RB'(s0)};
    bus.req_val   = {WW'(v1), WW'(v0)};
    bus.req_tk    = tk;
    bus.rdy       = r;
    bus.rb_flush  = fl;
  endtask

  task automatic idle();
    drive('0, 0, 0, 0, 0, '0, 1'b1, 1'b0);
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic nxt();
    @(posedge clk); #2;
  endtask

  bit prev_ld, is_ld;

  initial begin
    idle();
    #1 rst = 1'b1;
    at_neg();
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    nxt();
    rst = 1'b0;

    // Lone ALU streaming src 1..5.
    for (int s = 1; s <= 7; s++) begin
      if (s <= 5) drive(2'b01, s, 'h10 + s - 1, 0, 0, '0, 1'b1, 1'b0);
      else idle();
      at_neg();
      if (s <= 5) chk("stream_ready", 64'(bus.req_ready[0]), 64'd1);
      if (s >= 3) begin
        chk("stream_valid", 64'(bus.cdb_valid), 64'd1);
        chk("stream_src", 64'(bus.cdb_src), 64'(s - 2));
        chk("stream_val", 64'(bus.cdb_val), 64'('h10 + s - 3));
      end
      nxt();
    end

    // LD alone once to bring the pointer back to ALU, then drain.
    drive(2'b10, 0, 0, 9, 'h99, '0, 1'b1, 1'b0); nxt();
    idle(); nxt(); nxt();

    // Contention: both accepted at one edge.
    drive(2'b11, 3, 'hAA, 4, 'hBB, '0, 1'b1, 1'b0); nxt();
    idle(); at_neg();
    chk("cont_ready", 64'(bus.req_ready), 64'b01);
    nxt(); at_neg();
    chk("cont_src0", 64'(bus.cdb_src), 64'd3);
    chk("cont_val0", 64'(bus.cdb_val), 64'hAA);
    chk("cont_ready2", 64'(bus.req_ready), 64'b11);
    nxt(); at_neg();
    chk("cont_src1", 64'(bus.cdb_src), 64'd4);
    chk("cont_val1", 64'(bus.cdb_val), 64'hBB);
    nxt(); nxt();

    // Fairness: both valid for 8 cycles, beats must alternate.
    for (int k = 0; k <= 10; k++) begin
      if (k < 8) drive(2'b11, 10 + k, k, 20 + k, 'h100 + k, '0, 1'b1, 1'b0);
      else idle();
      at_neg();
      if (k >= 2) begin
        chk("fair_valid", 64'(bus.cdb_valid), 64'd1);
        is_ld = (bus.cdb_src >= 5'd20);
        if (k == 2) chk("fair_first", 64'(bus.cdb_src), 64'd10);
        else chk("fair_alt", 64'(is_ld), 64'(!prev_ld));
        prev_ld = is_ld;
      end
      nxt();
    end
    nxt(); nxt();

    // Stall with LD pending.
    drive(2'b10, 0, 0, 7, 'h77, 2'b10, 1'b1, 1'b0); nxt();
    for (int k = 0; k < 3; k++) begin
      drive('0, 0, 0, 0, 0, '0, 1'b0, 1'b0);
      at_neg();
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_valid", 64'(bus.cdb_valid), 64'd0);
      nxt();
    end
    idle(); nxt(); at_neg();
    chk("stall_valid_out", 64'(bus.cdb_valid), 64'd1);
    chk("stall_src", 64'(bus.cdb_src), 64'd7);
    chk("stall_tk", 64'(bus.cdb_tk), 64'd1);
    nxt();

    // Flush with both pending plus a new ALU offer.
    drive(2'b11, 12, 1, 13, 2, '0, 1'b1, 1'b0); nxt();
    drive(2'b01, 14, 3, 0, 0, '0, 1'b1, 1'b1); at_neg();
    chk("flush_ready", 64'(bus.req_ready), 64'd0);
    nxt();
    for (int k = 0; k < 4; k++) begin
      idle(); at_neg();
      chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
      if (k == 0) chk("flush_ready_after", 64'(bus.req_ready), 64'b11);
      nxt();
    end

    // Asynchronous reset mid-operation.
    drive(2'b11, 1, 'h51, 2, 'h52, '0, 1'b1, 1'b0); nxt();
    idle(); nxt(); at_neg();
    chk("pre_rst_src", 64'(bus.cdb_src), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_valid", 64'(bus.cdb_valid), 64'd0);
    chk("async_ready", 64'(bus.req_ready), 64'd0);
    chk("async_src", 64'(bus.cdb_src), 64'd0);
    nxt();
    rst = 1'b0;
    drive(2'b11, 5, 'h55, 6, 'h66, '0, 1'b1, 1'b0); nxt();
    idle(); nxt(); at_neg();
    chk("post_rst_first", 64'(bus.cdb_src), 64'd5);
    nxt(); nxt();

    // Randomized traffic including stalls and flushes.
    for (int c = 0; c < 400; c++) begin
      drive(N'($urandom), int'($urandom_range(0, 31)), int'($urandom),
            int'($urandom_range(0, 31)), int'($urandom), N'($urandom),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
      nxt();
    end
    idle(); nxt(); nxt(); nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
